// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the datapath control sequence and mem_responder.
`default_nettype none

interface mem_responder_if;
  logic        Read;
  logic        Write;
  logic [8:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ready;
  logic        Busy;

  modport master (
    output Read, Write, Address, DataIn,
    input  DataOut, Ready, Busy
  );

  modport slave (
    input  Read, Write, Address, DataIn,
    output DataOut, Ready, Busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// mem_responder: word memory with a wait-state IDLE/WAIT/DONE handshake FSM.
// Rev 1.0 - initial release.
`default_nettype none

module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 512
) (
  input  logic           Clock,
  input  logic           Clear,
  mem_responder_if.slave bus
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] cap_addr, req_addr, acc_addr;
  logic [31:0]   cap_data, acc_data;
  logic          cap_wr, acc_wr;
  logic          req, commit;
  logic [31:0]   mem [DEPTH];

  assign req      = bus.Read | bus.Write;
  assign req_addr = AW'(32'(bus.Address) % 32'(DEPTH));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nx   = WAIT_INIT;
          state_nx = (WAIT_INIT == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = DONE;
      end
      DONE: begin
        if (!req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the capture edge itself,
  // so the live request fields must bypass the capture registers.
  assign commit   = (state_nx == DONE) && (state != DONE);
  assign acc_wr   = (state == IDLE) ? bus.Write : cap_wr;
  assign acc_addr = (state == IDLE) ? req_addr  : cap_addr;
  assign acc_data = (state == IDLE) ? bus.DataIn : cap_data;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      cap_addr    <= '0;
      cap_data    <= 32'd0;
      cap_wr      <= 1'b0;
      bus.DataOut <= 32'd0;
      bus.Ready   <= 1'b0;
      bus.Busy    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req) begin
        cap_addr <= req_addr;
        cap_data <= bus.DataIn;
        cap_wr   <= bus.Write;
      end
      if (commit && !acc_wr) bus.DataOut <= mem[acc_addr];
      bus.Ready <= (state == DONE);
      bus.Busy  <= (state_nx != IDLE);
    end
  end

  // Storage is never cleared; Clear only blocks a commit on its edge.
  always_ff @(posedge Clock) begin
    if (!Clear && commit && acc_wr) mem[acc_addr] <= acc_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a transaction-level model.
`default_nettype none

module tb_mem_responder;

  logic Clock = 1'b0;
  logic Clear = 1'b1;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.WAIT_CYCLES(2), .DEPTH(512)) u_dut_a (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus_a)
  );

  mem_responder #(.WAIT_CYCLES(0), .DEPTH(256)) u_dut_b (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus_b)
  );

  always #5 Clock = ~Clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mdl   [2][512];
  bit          known [2][512];
  logic [31:0] last_rd [2];
  logic [8:0]  wq0 [$];
  logic [8:0]  wq1 [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit sel, input bit rd, input bit wr,
                         input logic [8:0] addr, input logic [31:0] data);
    if (sel) begin
      bus_b.Read = rd; bus_b.Write = wr; bus_b.Address = addr; bus_b.DataIn = data;
    end else begin
      bus_a.Read = rd; bus_a.Write = wr; bus_a.Address = addr; bus_a.DataIn = data;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.Ready : bus_a.Ready;
  endfunction

  function automatic logic bsy(input bit sel);
    return sel ? bus_b.Busy : bus_a.Busy;
  endfunction

  function automatic logic [31:0] dout(input bit sel);
    return sel ? bus_b.DataOut : bus_a.DataOut;
  endfunction

  // One transaction: Ready must appear WAIT_CYCLES+1 edges after capture,
  // with fields scrambled after capture and the request optionally dropped in WAIT.
  task automatic run_txn(input bit sel, input bit rd, input bit wr, input logic [8:0] addr,
                         input logic [31:0] data, input bit drop, input int hold);
    int n;
    bit seen;
    int idx;
    int w;
    w    = sel ? 0 : 2;
    idx  = int'(addr) % (sel ? 256 : 512);
    set_req(sel, rd, wr, addr, data);
    n    = 0;
    seen = 1'b0;
    while (n < 24 && !seen) begin
      @(negedge Clock);
      n++;
      if (n == 1) begin
        check("busy_cap", 32'(bsy(sel)), 32'd1);
        set_req(sel, drop ? 1'b0 : rd, drop ? 1'b0 : wr, 9'($urandom), $urandom);
      end
      seen = rdy(sel);
    end
    if (!seen) begin
      check("ready_timeout", 32'd0, 32'd1);
      set_req(sel, 1'b0, 1'b0, 9'd0, 32'd0);
      return;
    end
    check("latency", 32'(n - 1), 32'(w + 1));
    if (wr) begin
      check("dout_hold", dout(sel), last_rd[sel]);
      mdl[sel][idx] = data;
      if (!known[sel][idx]) begin
        if (sel) wq1.push_back(addr); else wq0.push_back(addr);
      end
      known[sel][idx] = 1'b1;
    end else begin
      check("rd_data", dout(sel), mdl[sel][idx]);
      last_rd[sel] = mdl[sel][idx];
    end
    if (!drop) begin
      repeat (hold) begin
        @(negedge Clock);
        check("ready_hold", 32'(rdy(sel)), 32'd1);
      end
      set_req(sel, 1'b0, 1'b0, 9'd0, 32'd0);
      @(negedge Clock);
    end
    @(negedge Clock);
    check("ready_fall", 32'(rdy(sel)), 32'd0);
    check("busy_idle", 32'(bsy(sel)), 32'd0);
  endtask

  initial begin
    bit         sel;
    bit         rose;
    int         sz;
    logic [8:0] a;

    set_req(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 9'd0, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    Clear = 1'b1;
    repeat (2) @(negedge Clock);
    check("rst_dout_a", bus_a.DataOut, 32'd0);
    check("rst_ready_a", 32'(bus_a.Ready), 32'd0);
    check("rst_busy_a", 32'(bus_a.Busy), 32'd0);
    check("rst_dout_b", bus_b.DataOut, 32'd0);
    check("rst_ready_b", 32'(bus_b.Ready), 32'd0);
    check("rst_busy_b", 32'(bus_b.Busy), 32'd0);
    Clear = 1'b0;
    @(negedge Clock);

    // Write then read back, then write+read collision on a second address.
    run_txn(1'b0, 1'b0, 1'b1, 9'h05A, 32'h12345678, 1'b0, 0);
    run_txn(1'b0, 1'b1, 1'b0, 9'h05A, 32'd0, 1'b0, 0);
    run_txn(1'b0, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 0);
    run_txn(1'b0, 1'b1, 1'b0, 9'h010, 32'd0, 1'b0, 0);
    // Held read with address changes, and a write dropped mid-wait.
    run_txn(1'b0, 1'b1, 1'b0, 9'h05A, 32'd0, 1'b0, 2);
    run_txn(1'b0, 1'b0, 1'b1, 9'h0AA, 32'h0BADF00D, 1'b1, 0);
    run_txn(1'b0, 1'b1, 1'b0, 9'h0AA, 32'd0, 1'b0, 0);

    // Zero-wait instance: held read, plus address wrap modulo 256.
    run_txn(1'b1, 1'b0, 1'b1, 9'h05A, 32'h12345678, 1'b0, 0);
    run_txn(1'b1, 1'b1, 1'b0, 9'h05A, 32'd0, 1'b0, 3);
    run_txn(1'b1, 1'b0, 1'b1, 9'h105, 32'hA5A50105, 1'b0, 0);
    run_txn(1'b1, 1'b1, 1'b0, 9'h005, 32'd0, 1'b0, 0);

    // Clear one edge after capture aborts the pending write.
    run_txn(1'b0, 1'b0, 1'b1, 9'h020, 32'h11112222, 1'b0, 0);
    set_req(1'b0, 1'b0, 1'b1, 9'h020, 32'hCAFEF00D);
    @(negedge Clock);
    check("abort_busy", 32'(bus_a.Busy), 32'd1);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    check("clr_ready", 32'(bus_a.Ready), 32'd0);
    check("clr_busy", 32'(bus_a.Busy), 32'd0);
    check("clr_dout_a", bus_a.DataOut, 32'd0);
    check("clr_dout_b", bus_b.DataOut, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    rose = 1'b0;
    repeat (6) begin
      @(negedge Clock);
      if (bus_a.Ready) rose = 1'b1;
    end
    check("clr_no_ready", 32'(rose), 32'd0);
    run_txn(1'b0, 1'b1, 1'b0, 9'h020, 32'd0, 1'b0, 0);

    // Request held through Clear is captured on the first edge after it.
    Clear = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 9'h05A, 32'd0);
    @(negedge Clock);
    check("clr_hold_busy", 32'(bus_a.Busy), 32'd0);
    Clear = 1'b0;
    run_txn(1'b0, 1'b1, 1'b0, 9'h05A, 32'd0, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      sel = 1'($urandom_range(0, 1));
      sz  = sel ? wq1.size() : wq0.size();
      if (sz == 0 || $urandom_range(0, 2) == 0) begin
        run_txn(sel, 1'($urandom_range(0, 3) == 0), 1'b1, 9'($urandom), $urandom,
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end else begin
        a = sel ? wq1[$urandom_range(0, sz - 1)] : wq0[$urandom_range(0, sz - 1)];
        if (sel && $urandom_range(0, 1) == 1) a = a ^ 9'h100;
        run_txn(sel, 1'b1, 1'b0, a, 32'd0, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning clock edges inserted between request capture and access commit, legal range 0-15.
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning number of 32-bit memory words.
REQ-003 The block SHALL have port Clock, input, 1, the single clock; all state SHALL change on its rising edge only.
REQ-004 The block SHALL have port Clear, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-005 The block SHALL have port Read, input, 1, read request from the datapath control sequence, level-held.
REQ-006 The block SHALL have port Write, input, 1, write request from the datapath control sequence, level-held.
REQ-007 The block SHALL have port Address, input, 9, word address driven from MAR.
REQ-008 The block SHALL have port DataIn, input, 32, write data driven from MDR.
REQ-009 The block SHALL have port DataOut, output, 32, registered read data (Mdatain to MDR).
REQ-010 The block SHALL have port Ready, output, 1, registered access-complete handshake.
REQ-011 The block SHALL have port Busy, output, 1, registered; high while a transaction is captured and not yet released.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-013 In IDLE, a rising edge with Read or Write high SHALL capture Address, DataIn and operation, and leave IDLE; no capture in any other state.
REQ-014 Read and Write high on the same capture edge SHALL be treated as Write only; DataOut unchanged.
REQ-015 A 4-bit wait counter SHALL load WAIT_CYCLES at capture and decrement once per edge in WAIT.
REQ-016 With WAIT_CYCLES=0, capture SHALL go directly IDLE->DONE; otherwise IDLE->WAIT, WAIT->DONE on the edge where the counter reaches 0.
REQ-017 The access SHALL commit on the edge entering DONE: write stores captured DataIn at captured address; read loads mem[captured address] into DataOut.
REQ-018 Latency: Ready SHALL rise exactly WAIT_CYCLES+1 edges after the capture edge.
REQ-019 Ready SHALL be high in DONE and low in every other state.
REQ-020 Busy SHALL be high in WAIT and DONE, low in IDLE.
REQ-021 Handshake: DONE->IDLE SHALL occur on the first edge with both Read and Write low; while either stays high, DONE persists with no further access.
REQ-022 Request dropped during WAIT SHALL NOT abort; the access commits, Ready is high for exactly one cycle, and the FSM then returns to IDLE.
REQ-023 Address, DataIn and request changes after capture SHALL NOT affect the committed transaction.
REQ-024 DataOut SHALL hold the most recent read value across writes and idle cycles.
REQ-025 Back-to-back: a new request SHALL need at least one IDLE cycle; min transaction period SHALL be WAIT_CYCLES+3 edges.
REQ-026 Address bits beyond log2(DEPTH) SHALL be ignored, wrapping modulo DEPTH.

Reset
REQ-027 Clear high at a rising edge SHALL force state IDLE, counter 0, DataOut 0x00000000, Ready 0, Busy 0.
REQ-028 Clear SHALL take priority over every request and transition, including the commit edge.
REQ-029 Clear asserted before the commit edge SHALL abort the pending write; memory SHALL remain unmodified.
REQ-030 Clear SHALL NOT initialise memory contents.
REQ-031 A request held high through Clear deassertion SHALL be captured on the first edge with Clear low.

Verification
REQ-032 WAIT_CYCLES=2; Write=1, Address=0x05A, DataIn=0x12345678 at edge 0 -> Ready high after edge 3; drop Write; later Read at 0x05A -> DataOut=0x12345678 when Ready rises.
REQ-033 WAIT_CYCLES=0; Read held 5 cycles at 0x05A -> Ready rises after edge 1, stays high 4 cycles, one commit only; IDLE after Read drops.
REQ-034 Read=Write=1, Address=0x010, DataIn=0xDEADBEEF, DataOut previously 0x12345678 -> mem[0x010]=0xDEADBEEF; DataOut stays 0x12345678.
REQ-035 Write to 0x020 with 0xCAFEF00D, Clear pulsed at edge 1 (WAIT_CYCLES=2) -> Ready never rises; outputs reset; later read of 0x020 returns the prior value.
REQ-036 Read of 0x05A then Address changed to 0x011 after capture -> DataOut=0x12345678; Write dropped in WAIT -> commit occurs, Ready high exactly one cycle.
